fb_write_arbiter: RTL and testbench
===================================

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, framebuffer word address width (640x480 fits).
REQ-002 SHALL have parameter DATA_W, default 32, pixel/color word width.
REQ-003 SHALL have parameter MAX_BURST, default 64, maximum beats per grant before forced release.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 3, per-requester beat valid (bit0 clear engine, bit1 rasterizer, bit2 SIMD unit).
REQ-007 SHALL have port req_addr, input, 3*ADDR_W, per-requester write address (requester i in slice i).
REQ-008 SHALL have port req_data, input, 3*DATA_W, per-requester write data.
REQ-009 SHALL have port req_last, input, 3, per-requester end-of-burst marker.
REQ-010 SHALL have port req_ready, output, 3, per-requester beat accept.
REQ-011 SHALL have port fb_valid, output, 1, framebuffer write strobe.
REQ-012 SHALL have port fb_addr, output, ADDR_W, framebuffer write address.
REQ-013 SHALL have port fb_wdata, output, DATA_W, framebuffer write data.
REQ-014 SHALL have port fb_ready, input, 1, framebuffer accepts the current beat.
REQ-015 SHALL have port grant_valid, output, 1, a requester currently holds the port.
REQ-016 SHALL have port grant_id, output, 2, index of the holding requester (0..2).

Function
REQ-017 SHALL implement FSM states IDLE and GRANT.
REQ-018 SHALL, in IDLE with any req_valid bit set, select the first set bit scanning from rr_ptr upward modulo 3, register it into grant_id, and enter GRANT next cycle.
REQ-019 SHALL keep req_ready all-zero in IDLE; arbitration costs exactly one cycle.
REQ-020 SHALL, in GRANT, drive req_ready[grant_id] = (!fb_valid || fb_ready) and all other req_ready bits 0.
REQ-021 SHALL count a beat accepted when req_valid[grant_id] && req_ready[grant_id] in the same cycle.
REQ-022 SHALL register an accepted beat's address and data into fb_addr/fb_wdata and set fb_valid the next cycle (latency 1).
REQ-023 SHALL hold fb_valid, fb_addr and fb_wdata stable while fb_valid && !fb_ready.
REQ-024 SHALL clear fb_valid after fb_ready unless a new beat is accepted in that same cycle (back-to-back: 1 beat/cycle at full throughput).
REQ-025 SHALL keep a beat counter, cleared on entry to GRANT, incremented per accepted beat.
REQ-026 SHALL return to IDLE after a beat accepted with req_last set, or the beat that makes the count equal MAX_BURST, whichever first; set rr_ptr = (grant_id+1) mod 3.
REQ-027 SHALL hold the grant while the granted requester drops req_valid mid-burst (no timeout).
REQ-028 SHALL ignore req_valid, req_addr, req_data, req_last of non-granted requesters.
REQ-029 SHALL drive grant_valid = 1 exactly in GRANT.
REQ-030 SHALL allow the last beat of a burst to remain pending in the output stage while the FSM returns to IDLE and re-arbitrates.

Reset
REQ-031 SHALL on rst set state IDLE, rr_ptr 0, grant_id 0, beat counter 0, fb_valid 0, fb_addr 0, fb_wdata 0, req_ready 0, grant_valid 0.
REQ-032 SHALL drop any pending output beat and in-progress burst when rst asserts mid-operation; no write issues after reset.

Verification
REQ-033 SHALL pass: after reset, only req_valid[0], 3 beats addr 0,1,2, last on beat 3, fb_ready=1 -> grant_id=0, fb writes addr 0,1,2 on consecutive cycles, then IDLE, rr_ptr=1.
REQ-034 SHALL pass: all three requesters valid continuously, single-beat bursts -> grants rotate 0,1,2,0,1,2.
REQ-035 SHALL pass: fb_ready held 0 for 4 cycles mid-burst -> fb_addr/fb_wdata stable, req_ready[grant_id]=0, no beat lost or duplicated.
REQ-036 SHALL pass: rasterizer streams 70 beats with no last, clear engine also valid -> rasterizer releases after 64 beats, grant passes to SIMD/clear per rr_ptr=2 scan.
REQ-037 SHALL pass: rst asserted during GRANT with fb_valid=1 -> next cycle fb_valid=0, grant_valid=0, req_ready=0.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter granting one of three burst writers access to a single framebuffer write port.
// One cycle to arbitrate, one-cycle registered output stage, bursts capped at MAX_BURST beats.
module fb_write_arbiter #(
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          req_valid,
  input  logic [3*ADDR_W-1:0] req_addr,
  input  logic [3*DATA_W-1:0] req_data,
  input  logic [2:0]          req_last,
  output logic [2:0]          req_ready,
  output logic                fb_valid,
  output logic [ADDR_W-1:0]   fb_addr,
  output logic [DATA_W-1:0]   fb_wdata,
  input  logic                fb_ready,
  output logic                grant_valid,
  output logic [1:0]          grant_id
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state_q;
  logic [1:0]          rr_ptr_q;
  logic [1:0]          grant_id_q;
  logic [CNT_W-1:0]    beat_cnt_q;
  logic                fb_valid_q;
  logic [ADDR_W-1:0]   fb_addr_q;
  logic [DATA_W-1:0]   fb_wdata_q;

  logic                stage_free;
  logic                accept;
  logic                burst_end;
  logic                found;
  logic [1:0]          pick;
  logic [1:0]          cand;
  logic [1:0]          rr_ptr_d;
  logic [CNT_W-1:0]    beat_cnt_d;
  logic [ADDR_W-1:0]   gnt_addr;
  logic [DATA_W-1:0]   gnt_data;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Scan requesters starting at rr_ptr, wrapping modulo 3.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr_q;
    cand  = rr_ptr_q;
    for (int k = 0; k < 3; k++) begin
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
      cand = inc3(cand);
    end
  end

  assign stage_free = !fb_valid_q || fb_ready;
  assign gnt_addr   = req_addr[grant_id_q*ADDR_W +: ADDR_W];
  assign gnt_data   = req_data[grant_id_q*DATA_W +: DATA_W];
  assign accept     = (state_q == GRANT) && req_valid[grant_id_q] && stage_free;
  assign beat_cnt_d = beat_cnt_q + 1'b1;
  assign burst_end  = req_last[grant_id_q] || (beat_cnt_d == CNT_W'(MAX_BURST));
  assign rr_ptr_d   = inc3(grant_id_q);

  always_comb begin
    req_ready = 3'b000;
    if (state_q == GRANT && !rst) req_ready[grant_id_q] = stage_free;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 2'd0;
      grant_id_q <= 2'd0;
      beat_cnt_q <= '0;
      fb_valid_q <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_id_q <= pick;
            beat_cnt_q <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          if (accept) begin
            beat_cnt_q <= beat_cnt_d;
            if (burst_end) begin
              state_q  <= IDLE;
              rr_ptr_q <= rr_ptr_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      // The last beat may still sit here while the FSM re-arbitrates.
      if (accept) begin
        fb_valid_q <= 1'b1;
        fb_addr_q  <= gnt_addr;
        fb_wdata_q <= gnt_data;
      end else if (fb_ready) begin
        fb_valid_q <= 1'b0;
      end
    end
  end

  assign fb_valid    = fb_valid_q;
  assign fb_addr     = fb_addr_q;
  assign fb_wdata    = fb_wdata_q;
  assign grant_valid = (state_q == GRANT);
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: single burst, rotation, stall, burst cap, mid-burst reset.
module tb_fb_write_arbiter;

  localparam int AW = 19;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      req_valid;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_data;
  logic [2:0]      req_last;
  logic [2:0]      req_ready;
  logic            fb_valid;
  logic [AW-1:0]   fb_addr;
  logic [DW-1:0]   fb_wdata;
  logic            fb_ready;
  logic            grant_valid;
  logic [1:0]      grant_id;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int wr_snap;

  fb_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready),
    .fb_valid(fb_valid), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_ready(fb_ready),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (fb_valid && fb_ready) wr_cnt <= wr_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 3'b000;
    req_last = 3'b000;
    fb_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    req_addr = '0;
    req_data = '0;
    do_reset();
    chk("rst_fb_valid", 64'(fb_valid), 64'd0);
    chk("rst_grant_valid", 64'(grant_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_fb_addr", 64'(fb_addr), 64'd0);
    chk("rst_fb_wdata", 64'(fb_wdata), 64'd0);

    // Single 3-beat burst from the clear engine.
    req_valid = 3'b001;
    set_req(0, 19'd0, 32'hA000);
    tick();
    chk("b1_grant_valid", 64'(grant_valid), 64'd1);
    chk("b1_grant_id", 64'(grant_id), 64'd0);
    chk("b1_req_ready", 64'(req_ready), 64'b001);
    tick();
    chk("b1_w0_valid", 64'(fb_valid), 64'd1);
    chk("b1_w0_addr", 64'(fb_addr), 64'd0);
    chk("b1_w0_data", 64'(fb_wdata), 64'hA000);
    set_req(0, 19'd1, 32'hA001);
    tick();
    chk("b1_w1_addr", 64'(fb_addr), 64'd1);
    set_req(0, 19'd2, 32'hA002);
    req_last = 3'b001;
    tick();
    chk("b1_w2_addr", 64'(fb_addr), 64'd2);
    chk("b1_w2_valid", 64'(fb_valid), 64'd1);
    chk("b1_idle", 64'(grant_valid), 64'd0);
    req_valid = 3'b000;
    tick();
    chk("b1_drain", 64'(fb_valid), 64'd0);
    // rr_ptr is now 1: with 0 and 2 requesting, 2 wins.
    req_valid = 3'b101;
    req_last = 3'b111;
    set_req(2, 19'h222, 32'hC222);
    chk("idle_ready_zero", 64'(req_ready), 64'd0);
    tick();
    chk("rr1_grant_id", 64'(grant_id), 64'd2);
    tick();
    chk("rr1_fb_addr", 64'(fb_addr), 64'h222);
    req_valid = 3'b000;

    // Rotation with single-beat bursts.
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 19'(32'h100 + i), 32'hB000 + i);
    req_valid = 3'b111;
    req_last = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rot%0d_grant_id", i), 64'(grant_id), 64'(i % 3));
      tick();
      chk($sformatf("rot%0d_fb_addr", i), 64'(fb_addr), 64'(32'h100 + i % 3));
      chk($sformatf("rot%0d_released", i), 64'(grant_valid), 64'd0);
    end
    req_valid = 3'b000;

    // Output stall for 4 cycles mid-burst.
    do_reset();
    wr_snap = wr_cnt;
    req_valid = 3'b001;
    set_req(0, 19'd10, 32'hD010);
    tick();
    tick();
    chk("st_first_addr", 64'(fb_addr), 64'd10);
    set_req(0, 19'd11, 32'hD011);
    fb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("st_ready_low", 64'(req_ready), 64'd0);
      tick();
      chk("st_hold_valid", 64'(fb_valid), 64'd1);
      chk("st_hold_addr", 64'(fb_addr), 64'd10);
      chk("st_hold_data", 64'(fb_wdata), 64'hD010);
    end
    fb_ready = 1'b1;
    #1;
    chk("st_ready_back", 64'(req_ready), 64'b001);
    tick();
    chk("st_w1_addr", 64'(fb_addr), 64'd11);
    set_req(0, 19'd12, 32'hD012);
    req_last = 3'b001;
    tick();
    chk("st_w2_addr", 64'(fb_addr), 64'd12);
    req_valid = 3'b000;
    tick();
    chk("st_write_count", 64'(wr_cnt - wr_snap), 64'd3);

    // Rasterizer streams with no last; capped at 64 beats.
    do_reset();
    req_valid = 3'b010;
    set_req(1, 19'd0, 32'h5000);
    tick();
    chk("cap_grant_id", 64'(grant_id), 64'd1);
    chk("cap_ready", 64'(req_ready), 64'b010);
    req_valid = 3'b011;
    set_req(0, 19'h3FF, 32'hEEEE);
    for (int k = 1; k <= 64; k++) begin
      tick();
      chk($sformatf("cap_beat%0d_addr", k), 64'(fb_addr), 64'(k - 1));
      chk($sformatf("cap_beat%0d_grant", k), 64'(grant_valid), 64'(k < 64));
      set_req(1, 19'(k), 32'h5000 + k);
    end
    chk("cap_last_data", 64'(fb_wdata), 64'h503F);
    chk("cap_idle_ready", 64'(req_ready), 64'd0);
    tick();
    chk("cap_next_grant", 64'(grant_id), 64'd0);
    chk("cap_next_valid", 64'(grant_valid), 64'd1);
    chk("cap_drained", 64'(fb_valid), 64'd0);
    req_valid = 3'b000;

    // Grant held while requester idles, then reset with a pending beat.
    do_reset();
    req_valid = 3'b001;
    set_req(0, 19'h55, 32'hF055);
    tick();
    tick();
    fb_ready = 1'b0;
    req_valid = 3'b110;
    tick();
    tick();
    chk("hold_grant_valid", 64'(grant_valid), 64'd1);
    chk("hold_grant_id", 64'(grant_id), 64'd0);
    chk("hold_fb_valid", 64'(fb_valid), 64'd1);
    wr_snap = wr_cnt;
    rst = 1'b1;
    tick();
    chk("mrst_fb_valid", 64'(fb_valid), 64'd0);
    chk("mrst_grant_valid", 64'(grant_valid), 64'd0);
    chk("mrst_req_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    req_valid = 3'b000;
    fb_ready = 1'b1;
    tick();
    tick();
    chk("mrst_no_write", 64'(wr_cnt - wr_snap), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
